alu_issue_unit: RTL and testbench

//  Issue-side front end for alu32: accepts decoded R-type ops over valid/ready and

---
 rtl/alu_issue_if.sv | 38 +++
 rtl/alu_issue_unit.sv | 135 +++++++++++++
 tb/tb_alu_issue_unit.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_if.sv
// ----------------------------------------------------------------------------
// alu_issue_if : request, alu32 and result buses of the ALU issue unit
// Revision     : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface alu_issue_if #(
  parameter int N = 32,
  parameter int M = 5
);
  logic         in_valid;
  logic         in_ready;
  logic [5:0]   in_funct;
  logic [M-1:0] in_shamt;
  logic [N-1:0] in_rs;
  logic [N-1:0] in_rt;
  logic [N-1:0] alu_a;
  logic [N-1:0] alu_b;
  logic [3:0]   alu_op;
  logic [N-1:0] alu_y;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_result;
  logic         out_err;

  // Environment side: decode stage, external alu32 and writeback consumer
  modport master (
    output in_valid, in_funct, in_shamt, in_rs, in_rt, alu_y, out_ready,
    input  in_ready, alu_a, alu_b, alu_op, out_valid, out_result, out_err
  );

  modport slave (
    input  in_valid, in_funct, in_shamt, in_rs, in_rt, alu_y, out_ready,
    output in_ready, alu_a, alu_b, alu_op, out_valid, out_result, out_err
  );
endinterface

`default_nettype wire

// File: rtl/alu_issue_unit.sv
// ----------------------------------------------------------------------------
// alu_issue_unit : decodes MIPS R-type funct for alu32, queues results in FIFO
// Revision       : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module alu_issue_unit #(
  parameter int N     = 32,
  parameter int M     = 5,
  parameter int DEPTH = 2
) (
  input  wire logic  clk,
  input  wire logic  rst,
  alu_issue_if.slave bus
);
  localparam int                c_ptr_w = $clog2(DEPTH);
  localparam logic [c_ptr_w:0]  c_full  = (c_ptr_w + 1)'(DEPTH);

  typedef enum logic [0:0] {IDLE = 1'b0, EXEC = 1'b1} state_t;

  state_t             r_state, w_state_nxt;
  logic [N-1:0]       r_alu_a, r_alu_b;
  logic [3:0]         r_alu_op;
  logic               r_err;
  logic [N-1:0]       r_mem_res [DEPTH];
  logic               r_mem_err [DEPTH];
  logic [c_ptr_w-1:0] r_wr_ptr, r_rd_ptr;
  logic [c_ptr_w:0]   r_count;
  logic [N-1:0]       r_last_res;
  logic               r_last_err;

  logic               w_accept, w_push, w_pop, w_not_empty;
  logic [N-1:0]       w_a, w_b;
  logic [3:0]         w_op;
  logic               w_err;

  assign bus.in_ready = ~rst & (r_state == IDLE) & (r_count < c_full);
  assign w_accept     = bus.in_valid & bus.in_ready;
  assign w_push       = (r_state == EXEC);
  assign w_not_empty  = (r_count != '0);
  assign w_pop        = w_not_empty & bus.out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = EXEC;
      EXEC:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Shifts take the shifted value from rt; variable shifts take amount from rs
  always_comb begin
    w_op  = 4'b0000;
    w_a   = '0;
    w_b   = '0;
    w_err = 1'b0;
    case (bus.in_funct)
      6'h20, 6'h21: begin w_op = 4'b0100; w_a = bus.in_rs; w_b = bus.in_rt; end
      6'h22, 6'h23: begin w_op = 4'b0101; w_a = bus.in_rs; w_b = bus.in_rt; end
      6'h24:        begin w_op = 4'b1010; w_a = bus.in_rs; w_b = bus.in_rt; end
      6'h25:        begin w_op = 4'b1000; w_a = bus.in_rs; w_b = bus.in_rt; end
      6'h26:        begin w_op = 4'b1011; w_a = bus.in_rs; w_b = bus.in_rt; end
      6'h00: begin w_op = 4'b1100; w_a = bus.in_rt; w_b = {{(N-M){1'b0}}, bus.in_shamt}; end
      6'h02: begin w_op = 4'b1101; w_a = bus.in_rt; w_b = {{(N-M){1'b0}}, bus.in_shamt}; end
      6'h03: begin w_op = 4'b1110; w_a = bus.in_rt; w_b = {{(N-M){1'b0}}, bus.in_shamt}; end
      6'h04: begin w_op = 4'b1100; w_a = bus.in_rt; w_b = {{(N-M){1'b0}}, bus.in_rs[M-1:0]}; end
      6'h06: begin w_op = 4'b1101; w_a = bus.in_rt; w_b = {{(N-M){1'b0}}, bus.in_rs[M-1:0]}; end
      6'h07: begin w_op = 4'b1110; w_a = bus.in_rt; w_b = {{(N-M){1'b0}}, bus.in_rs[M-1:0]}; end
      6'h18:        begin w_op = 4'b0110; w_a = bus.in_rs; w_b = bus.in_rt; end
      default:      w_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_alu_a  <= '0;
      r_alu_b  <= '0;
      r_alu_op <= 4'b0000;
      r_err    <= 1'b0;
    end else if (w_accept) begin
      r_alu_a  <= w_a;
      r_alu_b  <= w_b;
      r_alu_op <= w_op;
      r_err    <= w_err;
    end
  end

  assign bus.alu_a  = r_alu_a;
  assign bus.alu_b  = r_alu_b;
  assign bus.alu_op = r_alu_op;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem_res[i] <= '0;
        r_mem_err[i] <= 1'b0;
      end
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_last_res <= '0;
      r_last_err <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem_res[r_wr_ptr] <= r_err ? '0 : bus.alu_y;
        r_mem_err[r_wr_ptr] <= r_err;
        r_wr_ptr            <= r_wr_ptr + c_ptr_w'(1);
      end
      if (w_pop) begin
        r_last_res <= r_mem_res[r_rd_ptr];
        r_last_err <= r_mem_err[r_rd_ptr];
        r_rd_ptr   <= r_rd_ptr + c_ptr_w'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (c_ptr_w + 1)'(1);
        2'b01:   r_count <= r_count - (c_ptr_w + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // When empty, the head outputs keep showing the most recently popped entry
  assign bus.out_valid  = w_not_empty;
  assign bus.out_result = w_not_empty ? r_mem_res[r_rd_ptr] : r_last_res;
  assign bus.out_err    = w_not_empty ? r_mem_err[r_rd_ptr] : r_last_err;

endmodule

`default_nettype wire

// File: tb/tb_alu_issue_unit.sv
// ----------------------------------------------------------------------------
// tb_alu_issue_unit : directed stimulus, queue model and literal expectations
// Revision          : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_alu_issue_unit;
  localparam int N     = 32;
  localparam int M     = 5;
  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_issue_if #(.N(N), .M(M)) bus ();
  alu_issue_unit #(.N(N), .M(M), .DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Stand-in for the external alu32
  always_comb begin
    bus.alu_y = '0;
    case (bus.alu_op)
      4'b0100: bus.alu_y = bus.alu_a + bus.alu_b;
      4'b0101: bus.alu_y = bus.alu_a - bus.alu_b;
      4'b1010: bus.alu_y = bus.alu_a & bus.alu_b;
      4'b1000: bus.alu_y = bus.alu_a | bus.alu_b;
      4'b1011: bus.alu_y = bus.alu_a ^ bus.alu_b;
      4'b1100: bus.alu_y = bus.alu_a << bus.alu_b[M-1:0];
      4'b1101: bus.alu_y = bus.alu_a >> bus.alu_b[M-1:0];
      4'b1110: bus.alu_y = N'($signed(bus.alu_a) >>> bus.alu_b[M-1:0]);
      4'b0110: bus.alu_y = {16'h0, bus.alu_a[15:0]} * {16'h0, bus.alu_b[15:0]};
      default: bus.alu_y = '0;
    endcase
  end

  typedef struct packed {
    logic [N-1:0] res;
    logic         err;
    logic [3:0]   op;
  } exp_t;

  // Expected instruction result straight from MIPS semantics
  function automatic exp_t golden(input logic [5:0] f, input logic [N-1:0] rs,
                                  input logic [N-1:0] rt, input logic [M-1:0] sh);
    exp_t e;
    e = '0;
    case (f)
      6'h20, 6'h21: begin e.res = rs + rt; e.op = 4'b0100; end
      6'h22, 6'h23: begin e.res = rs - rt; e.op = 4'b0101; end
      6'h24: begin e.res = rs & rt; e.op = 4'b1010; end
      6'h25: begin e.res = rs | rt; e.op = 4'b1000; end
      6'h26: begin e.res = rs ^ rt; e.op = 4'b1011; end
      6'h00: begin e.res = rt << sh; e.op = 4'b1100; end
      6'h02: begin e.res = rt >> sh; e.op = 4'b1101; end
      6'h03: begin e.res = N'($signed(rt) >>> sh); e.op = 4'b1110; end
      6'h04: begin e.res = rt << rs[M-1:0]; e.op = 4'b1100; end
      6'h06: begin e.res = rt >> rs[M-1:0]; e.op = 4'b1101; end
      6'h07: begin e.res = N'($signed(rt) >>> rs[M-1:0]); e.op = 4'b1110; end
      6'h18: begin e.res = rs[15:0] * rt[15:0]; e.op = 4'b0110; end
      default: e.err = 1'b1;
    endcase
    return e;
  endfunction

  exp_t         q[$];
  exp_t         pend;
  bit           pend_v;
  logic [N-1:0] last_res;
  logic         last_err;

  always @(posedge clk or posedge rst) begin : model
    bit acc;
    if (rst) begin
      q.delete();
      pend_v   = 1'b0;
      last_res = '0;
      last_err = 1'b0;
    end else begin
      acc = bus.in_valid && !pend_v && (q.size() < DEPTH);
      if (q.size() > 0 && bus.out_ready) begin
        last_res = q[0].res;
        last_err = q[0].err;
        void'(q.pop_front());
      end
      if (pend_v) q.push_back(pend);
      pend_v = acc;
      if (acc) pend = golden(bus.in_funct, bus.in_rs, bus.in_rt, bus.in_shamt);
    end
  end

  always @(negedge clk) begin : compare
    if (rst) begin
      check("rst_in_ready",  {31'b0, bus.in_ready}, '0);
      check("rst_out_valid", {31'b0, bus.out_valid}, '0);
      check("rst_out_result", bus.out_result, '0);
      check("rst_alu_op",    {28'b0, bus.alu_op}, '0);
    end else begin
      check("in_ready",  {31'b0, bus.in_ready}, {31'b0, (!pend_v && q.size() < DEPTH)});
      check("out_valid", {31'b0, bus.out_valid}, {31'b0, (q.size() != 0)});
      if (q.size() != 0) begin
        check("out_result", bus.out_result, q[0].res);
        check("out_err", {31'b0, bus.out_err}, {31'b0, q[0].err});
      end else begin
        check("hold_result", bus.out_result, last_res);
        check("hold_err", {31'b0, bus.out_err}, {31'b0, last_err});
      end
      if (pend_v) check("alu_op", {28'b0, bus.alu_op}, {28'b0, pend.op});
    end
  end

  // Called just after a rising edge; returns just after the accepting edge
  task automatic issue(input logic [5:0] f, input logic [N-1:0] rs,
                       input logic [N-1:0] rt, input logic [M-1:0] sh);
    int waited;
    waited       = 0;
    bus.in_funct = f;
    bus.in_rs    = rs;
    bus.in_rt    = rt;
    bus.in_shamt = sh;
    bus.in_valid = 1'b1;
    while (!bus.in_ready) begin
      @(posedge clk); #1;
      waited++;
      if (waited > 50) begin
        n_tests++;
        n_fail++;
        $display("FAIL issue_timeout: in_ready stayed 0, expected 1 within 50 cycles");
        bus.in_valid = 1'b0;
        return;
      end
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_funct  = '0;
    bus.in_rs     = '0;
    bus.in_rt     = '0;
    bus.in_shamt  = '0;
    bus.out_ready = 1'b1;
    step(); step();
    check("reset_in_ready", {31'b0, bus.in_ready}, 32'd0);
    check("reset_alu_a", bus.alu_a, 32'd0);
    rst = 1'b0;
    step();
    check("ready_after_reset", {31'b0, bus.in_ready}, 32'd1);

    // add: result appears one edge after the EXEC cycle
    issue(6'h20, 32'd5, 32'd7, 5'd0);
    check("add_alu_op", {28'b0, bus.alu_op}, 32'b0100);
    check("add_not_yet_valid", {31'b0, bus.out_valid}, 32'd0);
    step();
    check("add_valid", {31'b0, bus.out_valid}, 32'd1);
    check("add_result", bus.out_result, 32'd12);
    check("add_err", {31'b0, bus.out_err}, 32'd0);
    step();
    check("empty_hold_result", bus.out_result, 32'd12);

    issue(6'h22, 32'd0, 32'd1, 5'd0);
    step();
    check("sub_wrap", bus.out_result, 32'hFFFF_FFFF);

    issue(6'h03, 32'd0, 32'h8000_0000, 5'd4);
    check("sra_alu_b", bus.alu_b, 32'd4);
    check("sra_alu_a", bus.alu_a, 32'h8000_0000);
    step();
    check("sra_result", bus.out_result, 32'hF800_0000);

    issue(6'h18, 32'h1234_0003, 32'h0000_0005, 5'd0);
    step();
    check("mult_result", bus.out_result, 32'd15);

    issue(6'h3F, 32'hDEAD_BEEF, 32'h1234_5678, 5'd3);
    check("illegal_alu_op", {28'b0, bus.alu_op}, 32'd0);
    check("illegal_alu_a", bus.alu_a, 32'd0);
    step();
    check("illegal_err", {31'b0, bus.out_err}, 32'd1);
    check("illegal_result", bus.out_result, 32'd0);

    issue(6'h04, 32'd35, 32'd1, 5'd0);
    check("sllv_alu_b", bus.alu_b, 32'd3);
    step();
    check("sllv_result", bus.out_result, 32'd8);

    // Back-to-back mix checked by the model only
    issue(6'h24, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd0);
    issue(6'h25, 32'h0000_00F0, 32'h0000_000F, 5'd0);
    issue(6'h26, 32'hAAAA_5555, 32'hFFFF_0000, 5'd0);
    issue(6'h00, 32'd0, 32'h0000_0001, 5'd31);
    issue(6'h02, 32'd0, 32'h8000_0000, 5'd31);
    issue(6'h07, 32'd36, 32'h8000_0010, 5'd0);
    issue(6'h23, 32'd3, 32'd10, 5'd0);
    step(); step();

    // Back-pressure: two results fill the FIFO, third request stalls
    bus.out_ready = 1'b0;
    issue(6'h20, 32'd1, 32'd1, 5'd0);
    issue(6'h25, 32'h0000_00F0, 32'h0000_000F, 5'd0);
    step();
    bus.in_funct = 6'h26;
    bus.in_rs    = 32'h0000_FF00;
    bus.in_rt    = 32'h0000_0FF0;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("full_in_ready", {31'b0, bus.in_ready}, 32'd0);
      check("full_head", bus.out_result, 32'd2);
      step();
    end
    bus.out_ready = 1'b1;
    step();
    check("release_head", bus.out_result, 32'd255);
    check("release_in_ready", {31'b0, bus.in_ready}, 32'd1);
    step();
    bus.in_valid = 1'b0;
    check("drained_valid", {31'b0, bus.out_valid}, 32'd0);
    step();
    check("third_result", bus.out_result, 32'h0000_F0F0);
    step();

    // Reset while an op is in EXEC and the FIFO holds a result
    bus.out_ready = 1'b0;
    issue(6'h20, 32'd2, 32'd3, 5'd0);
    step();
    issue(6'h21, 32'd4, 32'd4, 5'd0);
    #2 rst = 1'b1;
    #1;
    check("midrst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    check("midrst_in_ready", {31'b0, bus.in_ready}, 32'd0);
    check("midrst_result", bus.out_result, 32'd0);
    step();
    rst = 1'b0;
    check("postrst_valid", {31'b0, bus.out_valid}, 32'd0);
    step();
    check("postrst_ready", {31'b0, bus.in_ready}, 32'd1);
    check("postrst_empty", {31'b0, bus.out_valid}, 32'd0);
    bus.out_ready = 1'b1;
    issue(6'h23, 32'd10, 32'd3, 5'd0);
    step();
    check("postrst_subu", bus.out_result, 32'd7);
    step(); step(); step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

`default_nettype wire
